// File: rtl/sfifo_1w_2r_if.sv
// sfifo_1w_2r_if: write/pair-read handshake bundle for sfifo_1w_2r.
interface sfifo_1w_2r_if #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4
);
    logic [DATA_WIDTH-1:0]  Data_in;
    logic                   WriteEn_in;
    logic                   Full_out;
    logic                   ReadEn_in;
    logic                   Empty_out;
    logic [DATA_WIDTH-1:0]  Data_out_1;
    logic [DATA_WIDTH-1:0]  Data_out_2;
    logic                   Data_valid;
    logic [ADDRESS_WIDTH:0] Count_out;
    logic                   Error_out;

    modport master (
        output Data_in, WriteEn_in, ReadEn_in,
        input  Full_out, Empty_out, Data_out_1, Data_out_2, Data_valid, Count_out, Error_out
    );

    modport slave (
        input  Data_in, WriteEn_in, ReadEn_in,
        output Full_out, Empty_out, Data_out_1, Data_out_2, Data_valid, Count_out, Error_out
    );
endinterface

// File: rtl/sfifo_1w_2r.sv
// sfifo_1w_2r: one-word write, two-word pair read synchronous FIFO.
// Define FIFO_1W2R_ERROR_FLAG_EN to enable the sticky misuse flag on Error_out.
module sfifo_1w_2r #(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 4,
    parameter int FIFO_DEPTH    = 1 << ADDRESS_WIDTH
) (
    input logic         Clk,
    input logic         Clear_in,
    sfifo_1w_2r_if.slave bus
);
    localparam int CW = ADDRESS_WIDTH + 1;

    logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]    mem_d [FIFO_DEPTH];
    logic [ADDRESS_WIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]            count_q, count_d;
    logic [DATA_WIDTH-1:0]    out1_q, out1_d, out2_q, out2_d;
    logic                     valid_q, valid_d;
    logic                     full, empty, wr_acc, rd_acc;

    assign full  = count_q == CW'(FIFO_DEPTH);
    assign empty = count_q < CW'(2);

    // Reads sample mem_q, so a word written this cycle is never part of the pair.
    always_comb begin
        wr_acc   = bus.WriteEn_in && !full;
        rd_acc   = bus.ReadEn_in && !empty;
        mem_d    = mem_q;
        if (wr_acc) mem_d[wr_ptr_q] = bus.Data_in;
        wr_ptr_d = wr_acc ? wr_ptr_q + ADDRESS_WIDTH'(1) : wr_ptr_q;
        rd_ptr_d = rd_acc ? rd_ptr_q + ADDRESS_WIDTH'(2) : rd_ptr_q;
        count_d  = count_q + CW'(wr_acc) - (rd_acc ? CW'(2) : CW'(0));
        out1_d   = rd_acc ? mem_q[rd_ptr_q] : out1_q;
        out2_d   = rd_acc ? mem_q[rd_ptr_q + ADDRESS_WIDTH'(1)] : out2_q;
        valid_d  = rd_acc;
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            out1_q   <= '0;
            out2_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            out1_q   <= out1_d;
            out2_q   <= out2_d;
            valid_q  <= valid_d;
        end
    end

`ifdef FIFO_1W2R_ERROR_FLAG_EN
    logic error_q, error_d;

    always_comb begin
        error_d = error_q || (bus.WriteEn_in && full) || (bus.ReadEn_in && empty);
    end

    always_ff @(posedge Clk) begin
        if (Clear_in) error_q <= 1'b0;
        else          error_q <= error_d;
    end

    assign bus.Error_out = error_q;
`else
    assign bus.Error_out = 1'b0;
`endif

    assign bus.Full_out   = full;
    assign bus.Empty_out  = empty;
    assign bus.Count_out  = count_q;
    assign bus.Data_out_1 = out1_q;
    assign bus.Data_out_2 = out2_q;
    assign bus.Data_valid = valid_q;
endmodule

// File: tb/tb_sfifo_1w_2r.sv
// tb_sfifo_1w_2r: directed and randomized checks of sfifo_1w_2r against a queue model.
module tb_sfifo_1w_2r;
`ifdef FIFO_1W2R_ERROR_FLAG_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] q[$];
    logic [7:0] m_out1, m_out2;
    logic       m_valid, m_err;

    sfifo_1w_2r_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) bif ();

    sfifo_1w_2r #(.DATA_WIDTH(8), .ADDRESS_WIDTH(4)) dut (
        .Clk(clk),
        .Clear_in(rst),
        .bus(bif)
    );

    always #5 clk = ~clk;

    // One clock of stimulus; the model applies FIFO rules on whole words.
    task automatic step(input logic we, input logic [7:0] d, input logic re);
        bit full_now, empty_now;
        bif.WriteEn_in = we;
        bif.Data_in    = d;
        bif.ReadEn_in  = re;
        full_now  = q.size() == DEPTH;
        empty_now = q.size() < 2;
        m_valid   = re && !empty_now;
        if (m_valid) begin
            m_out1 = q.pop_front();
            m_out2 = q.pop_front();
        end
        if (we && !full_now) q.push_back(d);
        if (ERR_EN && ((we && full_now) || (re && empty_now))) m_err = 1'b1;
        @(posedge clk);
        #1;
        bif.WriteEn_in = 1'b0;
        bif.ReadEn_in  = 1'b0;
    endtask

    task automatic do_reset();
        bif.WriteEn_in = 1'b1;
        bif.ReadEn_in  = 1'b1;
        bif.Data_in    = 8'hAA;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        bif.WriteEn_in = 1'b0;
        bif.ReadEn_in  = 1'b0;
        q.delete();
        m_out1 = 0; m_out2 = 0; m_valid = 0; m_err = 0;
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk); #1;
        if (bif.Empty_out !== 1'b1) begin errors++; $display("FAIL reset_empty got %0d exp 1", bif.Empty_out); end
        checks++;
        if (bif.Full_out !== 1'b0) begin errors++; $display("FAIL reset_full got %0d exp 0", bif.Full_out); end
        checks++;
        if (bif.Count_out !== 5'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", bif.Count_out); end
        checks++;
        if (bif.Data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0d exp 0", bif.Data_valid); end
        checks++;
        if (bif.Data_out_1 !== 8'd0 || bif.Data_out_2 !== 8'd0) begin
            errors++; $display("FAIL reset_data got %0d,%0d exp 0,0", bif.Data_out_1, bif.Data_out_2);
        end
        checks++;
        if (bif.Error_out !== 1'b0) begin errors++; $display("FAIL reset_error got %0d exp 0", bif.Error_out); end
        checks++;
    endtask

    task automatic test_pairs();
        do_reset();
        for (int i = 1; i <= 4; i++) step(1, 8'(i), 0);
        for (int i = 0; i < 2; i++) begin
            step(0, 0, 1);
            if (bif.Data_valid !== 1'b1 || bif.Data_out_1 !== 8'(2*i+1) || bif.Data_out_2 !== 8'(2*i+2)) begin
                errors++;
                $display("FAIL pair%0d got v=%0d %0d,%0d exp v=1 %0d,%0d", i, bif.Data_valid,
                         bif.Data_out_1, bif.Data_out_2, 2*i+1, 2*i+2);
            end
            checks++;
        end
        step(0, 0, 1);
        if (bif.Data_valid !== 1'b0 || bif.Empty_out !== 1'b1 || bif.Count_out !== 5'd0) begin
            errors++;
            $display("FAIL pairs_drained got v=%0d e=%0d c=%0d exp v=0 e=1 c=0", bif.Data_valid,
                     bif.Empty_out, bif.Count_out);
        end
        checks++;
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 8'(i), 0);
        if (bif.Full_out !== 1'b1 || bif.Count_out !== 5'd16) begin
            errors++; $display("FAIL full_flag got f=%0d c=%0d exp f=1 c=16", bif.Full_out, bif.Count_out);
        end
        checks++;
        step(1, 8'd99, 0);
        if (bif.Count_out !== 5'd16) begin errors++; $display("FAIL full_17th got %0d exp 16", bif.Count_out); end
        checks++;
        for (int i = 0; i < 8; i++) begin
            step(0, 0, 1);
            if (bif.Data_out_1 !== 8'(2*i) || bif.Data_out_2 !== 8'(2*i+1)) begin
                errors++;
                $display("FAIL full_read%0d got %0d,%0d exp %0d,%0d", i, bif.Data_out_1, bif.Data_out_2, 2*i, 2*i+1);
            end
            checks++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 0; i < 15; i++) step(1, 8'(100+i), 0);
        for (int i = 0; i < 7; i++) step(0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 8'(200+i), 0);
        step(0, 0, 1);
        if (bif.Data_out_1 !== 8'd114 || bif.Data_out_2 !== 8'd200) begin
            errors++; $display("FAIL wrap_straddle got %0d,%0d exp 114,200", bif.Data_out_1, bif.Data_out_2);
        end
        checks++;
        step(0, 0, 1);
        if (bif.Data_out_1 !== 8'd201 || bif.Data_out_2 !== 8'd202) begin
            errors++; $display("FAIL wrap_low got %0d,%0d exp 201,202", bif.Data_out_1, bif.Data_out_2);
        end
        checks++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int i = 1; i <= 3; i++) step(1, 8'(i), 0);
        step(1, 8'd9, 1);
        if (bif.Data_out_1 !== 8'd1 || bif.Data_out_2 !== 8'd2 || bif.Count_out !== 5'd2) begin
            errors++;
            $display("FAIL simul_read got %0d,%0d c=%0d exp 1,2 c=2", bif.Data_out_1, bif.Data_out_2, bif.Count_out);
        end
        checks++;
        step(0, 0, 1);
        if (bif.Data_out_1 !== 8'd3 || bif.Data_out_2 !== 8'd9) begin
            errors++; $display("FAIL simul_next got %0d,%0d exp 3,9", bif.Data_out_1, bif.Data_out_2);
        end
        checks++;
    endtask

    task automatic test_leftover();
        do_reset();
        step(1, 8'd5, 0);
        step(0, 0, 1);
        if (bif.Data_valid !== 1'b0 || bif.Count_out !== 5'd1) begin
            errors++; $display("FAIL leftover_hold got v=%0d c=%0d exp v=0 c=1", bif.Data_valid, bif.Count_out);
        end
        checks++;
        if (bif.Error_out !== ERR_EN) begin errors++; $display("FAIL leftover_err got %0d exp %0d", bif.Error_out, ERR_EN); end
        checks++;
        step(1, 8'd6, 0);
        step(0, 0, 1);
        if (bif.Data_valid !== 1'b1 || bif.Data_out_1 !== 8'd5 || bif.Data_out_2 !== 8'd6) begin
            errors++;
            $display("FAIL leftover_pair got v=%0d %0d,%0d exp v=1 5,6", bif.Data_valid, bif.Data_out_1, bif.Data_out_2);
        end
        checks++;
        if (bif.Error_out !== ERR_EN) begin errors++; $display("FAIL err_sticky got %0d exp %0d", bif.Error_out, ERR_EN); end
        checks++;
        do_reset();
        #1;
        if (bif.Error_out !== 1'b0) begin errors++; $display("FAIL err_clear got %0d exp 0", bif.Error_out); end
        checks++;
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            step(1'($urandom_range(0, 99) < 60), 8'($urandom), 1'($urandom_range(0, 99) < 35));
            if (bif.Count_out !== 5'(q.size())) begin
                errors++; $display("FAIL rnd_count@%0d got %0d exp %0d", n, bif.Count_out, q.size());
            end
            checks++;
            if (bif.Full_out !== (q.size() == DEPTH) || bif.Empty_out !== (q.size() < 2)) begin
                errors++;
                $display("FAIL rnd_flags@%0d got f=%0d e=%0d exp f=%0d e=%0d", n, bif.Full_out, bif.Empty_out,
                         q.size() == DEPTH, q.size() < 2);
            end
            checks++;
            if (bif.Data_valid !== m_valid || bif.Data_out_1 !== m_out1 || bif.Data_out_2 !== m_out2) begin
                errors++;
                $display("FAIL rnd_data@%0d got v=%0d %0d,%0d exp v=%0d %0d,%0d", n, bif.Data_valid,
                         bif.Data_out_1, bif.Data_out_2, m_valid, m_out1, m_out2);
            end
            checks++;
            if (bif.Error_out !== m_err) begin
                errors++; $display("FAIL rnd_err@%0d got %0d exp %0d", n, bif.Error_out, m_err);
            end
            checks++;
        end
    endtask

    initial begin
        bif.Data_in    = 0;
        bif.WriteEn_in = 0;
        bif.ReadEn_in  = 0;
        test_reset();
        test_pairs();
        test_full();
        test_wrap();
        test_simultaneous();
        test_leftover();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/sfifo_1w_2r.md
# sfifo_1w_2r

Synchronous FIFO with one narrow write port and a paired read port. It accepts one word per clock and delivers two consecutive words per accepted read. It is the counterpart of the two-write/one-read FIFO in the SMEM pipeline: it splits a serial result stream back into word pairs for downstream stages that consume two entries per cycle. Storage is a register array with binary pointers; there is no clock-domain crossing.

## Interface
Parameters:
- DATA_WIDTH, 8, width of each stored word
- ADDRESS_WIDTH, 4, pointer width
- FIFO_DEPTH, 1 << ADDRESS_WIDTH, number of entries; legal values are ≥ 4 and a power of two

Ports:
- Clk  input  1  single clock; all state changes on its rising edge
- Clear_in  input  1  synchronous, active-high reset
- Data_in  input  DATA_WIDTH  write data
- WriteEn_in  input  1  write request
- Full_out  output  1  high when count == FIFO_DEPTH
- ReadEn_in  input  1  pair-read request
- Empty_out  output  1  high when count < 2 (no full pair available)
- Data_out_1  output  DATA_WIDTH  older word of the pair
- Data_out_2  output  DATA_WIDTH  next word of the pair
- Data_valid  output  1  pair on Data_out_1/2 produced by the read accepted at the previous edge
- Count_out  output  ADDRESS_WIDTH+1  current occupancy, 0..FIFO_DEPTH
- Error_out  output  1  sticky misuse flag (see Configuration)

## Operation
- State: mem[FIFO_DEPTH], wr_ptr and rd_ptr (ADDRESS_WIDTH bits each), count (ADDRESS_WIDTH+1 bits).
- Write accept: WriteEn_in && !Full_out. mem[wr_ptr] <= Data_in; wr_ptr <= wr_ptr+1 (mod FIFO_DEPTH).
- Read accept: ReadEn_in && !Empty_out. Data_out_1 <= mem[rd_ptr]; Data_out_2 <= mem[rd_ptr+1 mod FIFO_DEPTH]; rd_ptr <= rd_ptr+2 (mod FIFO_DEPTH). A pair may straddle the wrap.
- count update: +1 on write only; −2 on read only; −1 on both in the same cycle.
- A write is blocked when Full_out is high, even if a read is accepted in the same cycle. No write-through: a read never includes a word written in the same cycle.
- A request that is not accepted is dropped silently. Pointers, count and mem are unchanged by it.
- A single leftover word (count == 1) stays until a second word arrives.
- Full_out, Empty_out and Count_out are combinational decodes of the registered count.
- Data_out_1/2 hold their last value when no read is accepted.
- Clear_in overrides all activity in its cycle. Any write or read requested in that cycle is discarded.

## Timing
- Reset values: wr_ptr=0, rd_ptr=0, count=0, Data_out_1=0, Data_out_2=0, Data_valid=0, Error_out=0. This gives Empty_out=1, Full_out=0, Count_out=0. mem is not cleared.
- Write sampled at edge N → Count_out reflects it after edge N. The word is readable by a read request sampled at edge N+1.
- Read sampled at edge N → Data_out_1/2 and Data_valid=1 are visible after edge N and remain so until edge N+1. Latency is 1 cycle.
- Data_valid is high for exactly one cycle per accepted read. Back-to-back reads give continuous Data_valid.
- Steady state is one write per cycle and one read every other cycle.

## Configuration
- FIFO_1W2R_ERROR_FLAG_EN defined:
  - Error_out sets on WriteEn_in && Full_out, or on ReadEn_in && Empty_out.
  - Error_out stays high until Clear_in.
- Not defined: Error_out is tied to 0 and the detection logic is absent.

## Test plan
- Reset then idle: Clear_in=1 for 2 cycles, then 0 → Empty_out=1, Full_out=0, Count_out=0, Data_valid=0, Data_out_1/2=0.
- Write 1,2,3,4 on consecutive cycles, then hold ReadEn_in=1 → two Data_valid pulses on consecutive cycles: (1,2), then (3,4). Empty_out=1 afterwards, Count_out=0.
- Fill 16 words (0..15) with ADDRESS_WIDTH=4 → Full_out=1, Count_out=16. A 17th write is ignored. Eight reads return (0,1)…(14,15) in order.
- Wrap straddle: write 15 words and read 7 pairs (rd_ptr=14), then write 3 more (wr_ptr wraps to 2) → the next reads return the pair held at addresses 14/15, then the pair at 0/1, with no corruption.
- Simultaneous: with count=3, assert WriteEn_in (data 9) and ReadEn_in in the same cycle → oldest pair output, Count_out=2, and 9 is returned in the following pair.
- Odd leftover and error flag (macro defined): write one word 5, then ReadEn_in=1 → no Data_valid and Error_out=1. Write 6 → the next read returns (5,6) and Error_out stays 1 until Clear_in.
